// File: rtl/cpu_clock_enable.sv
// Game Boy T/M-cycle strobe generator with RUN/HALT/STOP gating of the CPU enable.
// A fractional phase accumulator divides the system clock down to the T-rate.
module cpu_clock_enable #(
    parameter int unsigned     ACC_WIDTH = 32,
    parameter longint unsigned INC       = 64'd4194304,
    parameter longint unsigned MOD       = 64'd100000000
) (
    input  logic       i_Clk,
    input  logic       i_nRst,
    input  logic       i_Halt,
    input  logic       i_Stop,
    input  logic       i_IntPending,
    input  logic       i_Wake,
    input  logic       i_Stall,
    output logic       o_TEnable,
    output logic       o_MEnable,
    output logic       o_CpuEnable,
    output logic [1:0] o_TPhase,
    output logic [1:0] o_State
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_HALT = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [ACC_WIDTH-1:0] INC_W = ACC_WIDTH'(INC);
    localparam logic [ACC_WIDTH-1:0] MOD_W = ACC_WIDTH'(MOD);

    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic [ACC_WIDTH-1:0] sum;
    logic [1:0]           phase_reg, phase_next;
    logic [1:0]           state_reg, state_next;
    logic                 t_en_reg, t_en_next;
    logic                 m_en_reg, m_en_next;
    logic                 cpu_en_reg, cpu_en_next;
    logic                 t_tick;
    logic                 m_boundary;

    always_comb begin
        sum         = acc_reg + INC_W;
        t_tick      = (state_reg != ST_STOP) && (sum >= MOD_W);
        m_boundary  = t_tick && (phase_reg == 2'd3);
        acc_next    = acc_reg;
        phase_next  = phase_reg;
        state_next  = state_reg;
        t_en_next   = 1'b0;
        m_en_next   = 1'b0;
        cpu_en_next = 1'b0;

        if (state_reg == ST_STOP) begin
            // Timebase is frozen; only the joypad wake can restart it.
            if (i_Wake) begin
                state_next = ST_RUN;
            end
        end else begin
            acc_next  = t_tick ? (sum - MOD_W) : sum;
            t_en_next = t_tick;
            m_en_next = m_boundary;
            if (t_tick) begin
                phase_next = phase_reg + 2'd1;
            end
            case (state_reg)
                ST_RUN: begin
                    if (m_boundary && !i_Stall) begin
                        cpu_en_next = 1'b1;
                        if (i_Stop) begin
                            state_next = ST_STOP;
                        end else if (i_Halt) begin
                            state_next = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    // Wake costs one M-cycle: no CPU pulse on the waking boundary.
                    if (m_boundary && i_IntPending) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            acc_reg    <= '0;
            phase_reg  <= 2'd0;
            state_reg  <= ST_RUN;
            t_en_reg   <= 1'b0;
            m_en_reg   <= 1'b0;
            cpu_en_reg <= 1'b0;
        end else begin
            acc_reg    <= acc_next;
            phase_reg  <= phase_next;
            state_reg  <= state_next;
            t_en_reg   <= t_en_next;
            m_en_reg   <= m_en_next;
            cpu_en_reg <= cpu_en_next;
        end
    end

    assign o_TEnable   = t_en_reg;
    assign o_MEnable   = m_en_reg;
    assign o_CpuEnable = cpu_en_reg;
    assign o_TPhase    = phase_reg;
    assign o_State     = state_reg;

endmodule
